// File: rtl/adder_share_pkg.sv
// Shared types and constants for the shared-adder arbiter.
// The S1 operand register layout lives here so the top and any future
// consumers agree on field order.
package adder_share_pkg;

  localparam int N    = 64;
  localparam int NREQ = 4;
  localparam int TAGW = 5;
  localparam int IDW  = $clog2(NREQ);

  typedef struct packed {
    logic            vld;
    logic            sub;
    logic [IDW-1:0]  id;
    logic [TAGW-1:0] tag;
    logic [N-1:0]    a;
    logic [N-1:0]    b;
  } s1_t;

  // Round-robin successor, wrapping NREQ-1 -> 0 (NREQ need not be a power of 2)
  function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] idx);
    return (int'(idx) == NREQ - 1) ? '0 : idx + IDW'(1);
  endfunction

endpackage

// File: rtl/adder_share_arbiter_rr.sv
// Round-robin arbiter: grants the first asserted request found when scanning
// upward from ptr with wrap-around. Purely combinational; the caller owns ptr.
module rr_arbiter #(
  parameter int  NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  // Scan from ptr upward; first hit wins, nothing granted when disabled
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!any && req[(int'(ptr) + k) % NREQ]) begin
          any                            = 1'b1;
          gnt[(int'(ptr) + k) % NREQ]    = 1'b1;
          gnt_idx                        = IDW'((int'(ptr) + k) % NREQ);
        end
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// One N-bit adder shared by NREQ requesters. Round-robin grant into an
// operand register (S1), then the sum register (S2) which is the output.
// Optional subtract support is built when ADDARB_SUB_EN is defined;
// otherwise req_sub is ignored and only the plain adder is present.
module adder_share_arbiter #(
  parameter int  N    = adder_share_pkg::N,
  parameter int  NREQ = adder_share_pkg::NREQ,
  parameter int  TAGW = adder_share_pkg::TAGW,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*N-1:0]    req_a,
  input  logic [NREQ*N-1:0]    req_b,
  input  logic [NREQ*TAGW-1:0] req_tag,
  input  logic [NREQ-1:0]      req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N:0]           rsp_sum,
  output logic [IDW-1:0]       rsp_id,
  output logic [TAGW-1:0]      rsp_tag
);
  import adder_share_pkg::s1_t;
  import adder_share_pkg::rr_next;

  // s1_t is sized from the package; reject overrides that would not fit it
  if (N != adder_share_pkg::N || NREQ != adder_share_pkg::NREQ ||
      TAGW != adder_share_pkg::TAGW) begin : g_param_chk
    $error("adder_share_arbiter parameters must match adder_share_pkg");
  end

  s1_t             s1_q, s1_d;
  logic            rsp_vld_q, rsp_vld_d;
  logic [N:0]      sum_q, sum_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic            adv1, adv2, arb_en;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [N:0]      sum_s1;

  // S2 can take a new value when empty or draining; S1 when empty or moving on
  assign adv2   = !rsp_vld_q || rsp_ready;
  assign adv1   = !s1_q.vld || adv2;
  // no grants while reset is held, so nothing looks accepted during reset
  assign arb_en = adv1 && rst_n;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  assign req_ready = gnt;

`ifdef ADDARB_SUB_EN
  // a - b as a + ~b + 1; bit N then reads as the no-borrow flag
  assign sum_s1 = {1'b0, s1_q.a} + {1'b0, (s1_q.sub ? ~s1_q.b : s1_q.b)}
                + {{N{1'b0}}, s1_q.sub};
`else
  assign sum_s1 = {1'b0, s1_q.a} + {1'b0, s1_q.b};
  logic unused_sub;
  assign unused_sub = ^{req_sub, s1_q.sub};
`endif

  // S1 load: capture the granted requester's operands when S1 can advance
  always_comb begin
    s1_d = s1_q;
    if (adv1) begin
      s1_d.vld = gnt_any;
      if (gnt_any) begin
        s1_d.id  = gnt_idx;
        s1_d.tag = req_tag[int'(gnt_idx) * TAGW +: TAGW];
        s1_d.a   = req_a[int'(gnt_idx) * N +: N];
        s1_d.b   = req_b[int'(gnt_idx) * N +: N];
`ifdef ADDARB_SUB_EN
        s1_d.sub = req_sub[gnt_idx];
`else
        s1_d.sub = 1'b0;
`endif
      end
    end
  end

  // S2 load: result register holds under backpressure and when empty
  always_comb begin
    rsp_vld_d = rsp_vld_q;
    sum_d     = sum_q;
    id_d      = id_q;
    tag_d     = tag_q;
    if (adv2) begin
      rsp_vld_d = s1_q.vld;
      if (s1_q.vld) begin
        sum_d = sum_s1;
        id_d  = s1_q.id;
        tag_d = s1_q.tag;
      end
    end
  end

  // pointer moves past the winner only on an actual accept
  always_comb begin
    rr_ptr_d = gnt_any ? rr_next(gnt_idx) : rr_ptr_q;
  end

  // pipeline and pointer state; reset drops everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      rsp_vld_q <= 1'b0;
      sum_q     <= '0;
      id_q      <= '0;
      tag_q     <= '0;
      rr_ptr_q  <= '0;
    end else begin
      s1_q      <= s1_d;
      rsp_vld_q <= rsp_vld_d;
      sum_q     <= sum_d;
      id_q      <= id_d;
      tag_q     <= tag_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_vld_q;
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;
  assign rsp_tag   = tag_q;

endmodule
